// File: rtl/fwrisc_prog_pkg.sv
// Shared types and constants for the boot-time program loader.
package fwrisc_prog_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    FULL = 2'd2
  } prog_state_e;

  // Word that terminates a program image; never written to the ITCM.
  localparam logic [31:0] PROG_END_MARKER = 32'hFFFF_FFFF;

  // Idle cycles before a stale partial word is dropped.
  localparam int unsigned PROG_TIMEOUT_DEFAULT = 32'd1_000_000;

endpackage

// File: rtl/fwrisc_prog_word_asm.sv
// Byte-to-word assembler: shifts bytes in MSB-first and drops a partial word after an idle timeout.
module fwrisc_prog_word_asm
  import fwrisc_prog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PROG_TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned IdleW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned IdleLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TimeoutOn = (TIMEOUT_CYCLES != 0);

  // Only the three oldest bytes need storing; the fourth comes straight from rx_data_i.
  logic [23:0]      shift_q, shift_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout_hit;

  assign timeout_hit = TimeoutOn && (idle_q == IdleW'(IdleLast));

  // Next-state: accept bytes, track idle time while a word is partially assembled.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    idle_d     = idle_q;
    if (enable_i) begin
      if (rx_valid_i) begin
        // A byte on the timeout cycle wins over the discard.
        shift_d    = {shift_q[15:0], rx_data_i};
        byte_cnt_d = byte_cnt_q + 2'd1;
        idle_d     = '0;
      end else if (byte_cnt_q == 2'd0) begin
        idle_d = '0;
      end else if (timeout_hit) begin
        shift_d    = '0;
        byte_cnt_d = 2'd0;
        idle_d     = '0;
      end else if (TimeoutOn) begin
        idle_d = idle_q + IdleW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= 2'd0;
      idle_q     <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
    end
  end

  assign word_o       = {shift_q, rx_data_i};
  assign word_valid_o = enable_i && rx_valid_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/fwrisc_prog_loader.sv
// Boot-time program loader: UART bytes -> 32-bit words -> consecutive ITCM writes.
module fwrisc_prog_loader
  import fwrisc_prog_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DEPTH          = 4096,
  parameter logic [31:0] END_MARKER     = PROG_END_MARKER,
  parameter int unsigned TIMEOUT_CYCLES = PROG_TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_en_o,
  output logic              full_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              loading_o,
  output logic              done_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic [31:0]       checksum_o,
  output logic              core_reset_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  prog_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic [31:0]       word;
  logic              word_valid;

  fwrisc_prog_word_asm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_word_asm (
    .clock       (clock),
    .reset       (reset),
    .enable_i    (state_q == LOAD),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  // Next-state: act on each completed word while loading; DONE/FULL are terminal.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = done_q;
    full_d       = full_q;
    if (state_q == LOAD && word_valid) begin
      if (word == END_MARKER) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        mem_we_d     = 1'b1;
        mem_addr_d   = addr_q;
        mem_wdata_d  = word;
        word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
        checksum_d   = checksum_q + word;
        if (addr_q == LastAddr) begin
          // Last slot: addr is never used again, so hold it rather than overflow ADDR_W.
          state_d = FULL;
          full_d  = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LOAD;
      addr_q       <= '0;
      word_count_q <= '0;
      checksum_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      full_q       <= full_d;
    end
  end

  assign loading_o    = (state_q == LOAD);
  assign rx_en_o      = loading_o;
  assign core_reset_o = reset | loading_o;
  assign full_o       = full_q;
  assign done_o       = done_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign word_count_o = word_count_q;
  assign checksum_o   = checksum_q;

endmodule
